// File: rtl/transpose_job_ctrl.sv
// transpose_job_ctrl
//   Sequences one transposer job: accepts a command, streams nwords input words into the
//   transposer block by block, waits for the MVU writes of the whole job, then reports done.
//   A block is B = prec*NUM_WORDS/XLEN input words and produces prec MVU writes.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   cmd_valid/ready    job command handshake (ready only while idle)
//   cmd_prec           element precision (1..MAX_DATA_PREC)
//   cmd_baddr          MVU start address of the first block
//   cmd_nwords         number of input words in the job (multiple of B)
//   in_valid/ready     input word stream handshake, in_data carries the word
//   tr_start           high while feeding the transposer
//   tr_prec, tr_baddr  latched precision and current block address (zero-extended)
//   tr_iword           input word forwarded on transfer cycles, zero otherwise
//   tr_busy            transposer busy, stalls the input stream
//   tr_mvu_wr_en       one pulse per MVU write done by the transposer
//   job_done           one-cycle pulse when the job completes
//   job_err            one-cycle pulse on a rejected command or a surplus MVU write
//   job_active         high from job start until the done cycle inclusive
module transpose_job_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_WORDS     = 64,
    parameter int unsigned MVU_ADDR_LEN  = 15,
    parameter int unsigned MAX_DATA_PREC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [4:0]              cmd_prec,
    input  logic [MVU_ADDR_LEN-1:0] cmd_baddr,
    input  logic [15:0]             cmd_nwords,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_data,
    output logic                    tr_start,
    output logic [31:0]             tr_prec,
    output logic [31:0]             tr_baddr,
    output logic [XLEN-1:0]         tr_iword,
    input  logic                    tr_busy,
    input  logic                    tr_mvu_wr_en,
    output logic                    job_done,
    output logic                    job_err,
    output logic                    job_active
);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [4:0]              prec_q;
    logic [MVU_ADDR_LEN-1:0] baddr_q;      // address of the block currently being fed
    logic [15:0]             nwords_q;
    logic [31:0]             blk_len_q;    // B for the latched precision
    logic [31:0]             exp_wr_q;     // MVU writes expected for the whole job
    logic [31:0]             word_cnt_q;   // words transferred in the current block
    logic [15:0]             xfer_cnt_q;   // words transferred in the job
    logic [31:0]             wr_cnt_q;     // MVU writes seen, saturates at exp_wr_q
    logic                    job_done_q;
    logic                    job_err_q;

    // Command decode, evaluated on the accept cycle
    logic [31:0] cmd_blk_len;
    logic [31:0] cmd_blk_div;
    logic [31:0] cmd_exp_wr;
    logic        cmd_bad;

    always_comb begin
        cmd_blk_len = (32'(cmd_prec) * NUM_WORDS) / XLEN;
        // Keeps the divisor legal; a zero block length is rejected anyway
        cmd_blk_div = (cmd_blk_len == 32'd0) ? 32'd1 : cmd_blk_len;
        cmd_exp_wr  = (32'(cmd_nwords) * XLEN) / NUM_WORDS;
        cmd_bad     = (cmd_prec == 5'd0) ||
                      (32'(cmd_prec) > MAX_DATA_PREC) ||
                      (cmd_nwords == 16'd0) ||
                      (cmd_blk_len == 32'd0) ||
                      ((32'(cmd_nwords) % cmd_blk_div) != 32'd0);
    end

    logic xfer;
    logic blk_last;
    logic job_last;

    assign cmd_ready  = (state_q == StIdle);
    assign tr_start   = (state_q == StFeed);
    assign in_ready   = (state_q == StFeed) && !tr_busy;
    assign xfer       = in_valid && in_ready;
    assign tr_iword   = xfer ? in_data : '0;
    assign tr_prec    = 32'(prec_q);
    assign tr_baddr   = 32'(baddr_q);
    assign job_active = (state_q != StIdle);
    assign job_done   = job_done_q;
    assign job_err    = job_err_q;

    assign blk_last = (word_cnt_q == blk_len_q - 32'd1);
    assign job_last = ((xfer_cnt_q + 16'd1) == nwords_q);

    // Write counting is live only while a job is feeding or draining
    logic [31:0] wr_cnt_nxt;
    logic        wr_extra;

    always_comb begin
        wr_cnt_nxt = wr_cnt_q;
        wr_extra   = 1'b0;
        if (tr_mvu_wr_en && ((state_q == StFeed) || (state_q == StDrain))) begin
            if (wr_cnt_q < exp_wr_q) begin
                wr_cnt_nxt = wr_cnt_q + 32'd1;
            end else begin
                wr_extra = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prec_q     <= '0;
            baddr_q    <= '0;
            nwords_q   <= '0;
            blk_len_q  <= '0;
            exp_wr_q   <= '0;
            word_cnt_q <= '0;
            xfer_cnt_q <= '0;
            wr_cnt_q   <= '0;
            job_done_q <= 1'b0;
            job_err_q  <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            job_err_q  <= wr_extra;
            wr_cnt_q   <= wr_cnt_nxt;

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            job_err_q <= 1'b1;
                        end else begin
                            prec_q     <= cmd_prec;
                            baddr_q    <= cmd_baddr;
                            nwords_q   <= cmd_nwords;
                            blk_len_q  <= cmd_blk_len;
                            exp_wr_q   <= cmd_exp_wr;
                            word_cnt_q <= '0;
                            xfer_cnt_q <= '0;
                            wr_cnt_q   <= '0;
                            state_q    <= StFeed;
                        end
                    end
                end

                StFeed: begin
                    if (xfer) begin
                        xfer_cnt_q <= xfer_cnt_q + 16'd1;
                        if (blk_last) begin
                            // Next block lands prec rows further on, wrapping in the bank
                            word_cnt_q <= '0;
                            baddr_q    <= baddr_q + MVU_ADDR_LEN'(prec_q);
                        end else begin
                            word_cnt_q <= word_cnt_q + 32'd1;
                        end
                        if (job_last) begin
                            state_q <= StDrain;
                        end
                    end
                end

                StDrain: begin
                    // A final write arriving with busy already low completes this cycle
                    if ((wr_cnt_nxt == exp_wr_q) && !tr_busy) begin
                        state_q    <= StDone;
                        job_done_q <= 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transpose_job_ctrl.sv
module tb_transpose_job_ctrl;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_WORDS = 64;
    localparam int unsigned AW        = 15;
    localparam int unsigned MAXP      = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [4:0]      cmd_prec = '0;
    logic [AW-1:0]   cmd_baddr = '0;
    logic [15:0]     cmd_nwords = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_data = '0;
    logic            tr_start;
    logic [31:0]     tr_prec;
    logic [31:0]     tr_baddr;
    logic [XLEN-1:0] tr_iword;
    logic            tr_busy = 1'b0;
    logic            tr_mvu_wr_en = 1'b0;
    logic            job_done;
    logic            job_err;
    logic            job_active;

    int n_checks = 0;
    int n_errors = 0;

    transpose_job_ctrl #(
        .XLEN          (XLEN),
        .NUM_WORDS     (NUM_WORDS),
        .MVU_ADDR_LEN  (AW),
        .MAX_DATA_PREC (MAXP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_prec     (cmd_prec),
        .cmd_baddr    (cmd_baddr),
        .cmd_nwords   (cmd_nwords),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .tr_start     (tr_start),
        .tr_prec      (tr_prec),
        .tr_baddr     (tr_baddr),
        .tr_iword     (tr_iword),
        .tr_busy      (tr_busy),
        .tr_mvu_wr_en (tr_mvu_wr_en),
        .job_done     (job_done),
        .job_err      (job_err),
        .job_active   (job_active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All outputs quiet, controller idle and ready
    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_tr_start"}, tr_start, 0);
        check_eq({tag, "_tr_prec"}, tr_prec, 0);
        check_eq({tag, "_tr_baddr"}, tr_baddr, 0);
        check_eq({tag, "_tr_iword"}, tr_iword, 0);
        check_eq({tag, "_job_done"}, job_done, 0);
        check_eq({tag, "_job_err"}, job_err, 0);
        check_eq({tag, "_job_active"}, job_active, 0);
    endtask

    // One job end to end. rv: random in_valid, rb: random mid-block stalls,
    // rst_after: reset after that many transfers (0 = never), xwr: inject one surplus write.
    task automatic run_job(input int prec, input int baddr, input int nwords, input bit rv,
                           input bit rb, input int rst_after, input bit xwr);
        int          blk, expw, woff, blen;
        int          sent, blk_sent, blk_left, stall_left, wr_total, phase, nphase, cyc;
        bit          bad, busy, wr, xfer, err_next, fin;
        logic [31:0] words[$];
        logic [31:0] exp_addr;

        blk  = prec * NUM_WORDS / XLEN;
        expw = nwords * XLEN / NUM_WORDS;
        bad  = (prec == 0) || (prec > MAXP) || (nwords == 0) || (blk == 0);
        if (!bad && (nwords % blk) != 0) bad = 1'b1;
        woff = xwr ? 2 : 0;
        blen = ((prec > 8) ? prec : 8) + 1 + woff;
        for (int i = 0; i < nwords; i++) words.push_back($urandom);

        // Accept cycle: stray in_valid and a write pulse while idle must be ignored
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_prec     = prec[4:0];
        cmd_baddr    = baddr[AW-1:0];
        cmd_nwords   = nwords[15:0];
        in_valid     = 1'b1;
        in_data      = $urandom;
        tr_busy      = 1'b0;
        tr_mvu_wr_en = 1'b1;
        #1;
        check_eq("accept_cmd_ready", cmd_ready, 1);
        check_eq("idle_in_ready", in_ready, 0);
        check_eq("idle_tr_iword", tr_iword, 0);
        @(negedge clk);
        cmd_valid    = 1'b0;
        in_valid     = 1'b0;
        tr_mvu_wr_en = 1'b0;

        if (bad) begin
            #1;
            check_eq("reject_job_err", job_err, 1);
            check_eq("reject_cmd_ready", cmd_ready, 1);
            check_eq("reject_tr_start", tr_start, 0);
            check_eq("reject_job_active", job_active, 0);
            @(negedge clk);
            #1;
            check_eq("reject_err_pulse_len", job_err, 0);
            check_eq("reject_tr_start2", tr_start, 0);
            return;
        end

        sent = 0; blk_sent = 0; blk_left = 0; stall_left = 0; wr_total = 0;
        phase = 0; err_next = 1'b0; fin = 1'b0; cyc = 0;
        while (!fin && cyc < 3000) begin
            if (rst_after > 0 && sent == rst_after) begin
                rst = 1'b1; in_valid = 1'b0; tr_busy = 1'b0; tr_mvu_wr_en = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_idle_outputs("after_rst");
                fin = 1'b1;
            end else begin
                if (rb && phase == 0 && blk_left == 0 && stall_left == 0 && blk_sent > 0 &&
                    $urandom_range(0, 3) == 0)
                    stall_left = $urandom_range(1, 3);
                wr = (blk_left > woff) && (blk_left - woff <= prec);
                if (xwr && phase == 1 && blk_left == 2) wr = 1'b1;
                busy = (blk_left > 1) || (stall_left > 0);
                tr_busy      = busy;
                tr_mvu_wr_en = wr;
                in_valid     = rv ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data      = (sent < nwords) ? words[sent] : $urandom;
                #1;
                xfer = (phase == 0) && in_valid && !busy;
                check_eq("tr_start", tr_start, 32'(phase == 0));
                check_eq("in_ready", in_ready, 32'((phase == 0) && !busy));
                check_eq("tr_iword", tr_iword, xfer ? words[sent] : 32'd0);
                check_eq("job_active", job_active, 1);
                check_eq("cmd_ready_busy", cmd_ready, 0);
                check_eq("job_done", job_done, 32'(phase == 2));
                check_eq("job_err", job_err, 32'(err_next));
                if (phase == 0) begin
                    exp_addr = 32'((baddr + (sent / blk) * prec) % (1 << AW));
                    check_eq("tr_baddr", tr_baddr, exp_addr);
                    check_eq("tr_prec", tr_prec, 32'(prec));
                end
                if (phase == 2) begin
                    tr_busy = 1'b0; tr_mvu_wr_en = 1'b0; in_valid = 1'b0;
                    @(negedge clk);
                    #1;
                    check_eq("post_done_cmd_ready", cmd_ready, 1);
                    check_eq("post_done_active", job_active, 0);
                    check_eq("post_done_pulse_len", job_done, 0);
                    check_eq("post_done_err", job_err, 0);
                    check_eq("job_words", sent, nwords);
                    fin = 1'b1;
                end else begin
                    err_next = 1'b0;
                    if (wr) begin
                        if (wr_total >= expw) err_next = 1'b1;
                        else wr_total++;
                    end
                    nphase = phase;
                    if (blk_left > 0) blk_left--;
                    if (stall_left > 0) stall_left--;
                    if (xfer) begin
                        sent++;
                        blk_sent++;
                        if (blk_sent == blk) begin
                            blk_sent = 0;
                            blk_left = blen;
                        end
                        if (sent == nwords) nphase = 1;
                    end
                    if (phase == 1 && wr_total == expw && !busy) nphase = 2;
                    phase = nphase;
                    cyc++;
                    @(negedge clk);
                end
            end
        end
        check_eq("job_finished_in_budget", 32'(fin), 1);
    endtask

    initial begin
        int prec, blk, nwords;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        run_job(8, 0, 16, 1'b0, 1'b0, 0, 1'b0);        // single block
        run_job(8, 'h7FF8, 32, 1'b0, 1'b0, 0, 1'b0);   // address wrap on second block
        run_job(3, 0, 7, 1'b0, 1'b0, 0, 1'b0);         // not a multiple of B
        run_job(2, 5, 8, 1'b1, 1'b1, 0, 1'b0);         // random valid and stalls
        run_job(4, 0, 16, 1'b0, 1'b0, 5, 1'b0);        // reset mid-job
        run_job(4, 0, 16, 1'b1, 1'b0, 0, 1'b0);        // clean job after reset
        run_job(0, 0, 16, 1'b0, 1'b0, 0, 1'b0);        // zero precision
        run_job(17, 0, 34, 1'b0, 1'b0, 0, 1'b0);       // precision too large
        run_job(4, 0, 0, 1'b0, 1'b0, 0, 1'b0);         // zero words
        run_job(16, 'h1234, 64, 1'b1, 1'b1, 0, 1'b0);  // max precision
        run_job(2, 0, 8, 1'b0, 1'b0, 0, 1'b1);         // surplus write while draining

        for (int j = 0; j < 25; j++) begin
            prec = $urandom_range(0, 17);
            blk  = prec * NUM_WORDS / XLEN;
            if (blk > 0 && $urandom_range(0, 4) != 0) nwords = blk * $urandom_range(1, 4);
            else nwords = $urandom_range(0, 70);
            run_job(prec, $urandom_range(0, (1 << AW) - 1), nwords, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
